// File: rtl/edge_event_arbiter.sv
// Rising-edge capture on N_CH level inputs with sticky pending flags and round-robin
// delivery over a valid/ready handshake. Define EDGE_ARB_SYNC_EN to add 2-flop input synchronisers.
module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    input  logic [N_CH-1:0] level,
    output logic            evt_valid,
    output logic [CH_W-1:0] evt_ch,
    input  logic            evt_ready,
    output logic [N_CH-1:0] pending,
    output logic [N_CH-1:0] ovf,
    input  logic [N_CH-1:0] ovf_clr,
    output logic            busy
);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] rr_ptr_nxt;
    logic [CH_W-1:0] evt_ch_nxt;
    logic [N_CH-1:0] level_s;
    logic [N_CH-1:0] level_q;
    logic [N_CH-1:0] edge_det;
    logic [N_CH-1:0] clr;
    logic            handshake;
    logic            pick_found;
    logic [CH_W-1:0] pick_idx;
    logic [CH_W-1:0] cand;
    int              cand_sum;

`ifdef EDGE_ARB_SYNC_EN
    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= level;
            sync2 <= sync1;
        end
    end

    assign level_s = sync2;
`else
    assign level_s = level;
`endif

    assign edge_det  = {N_CH{en}} & level_s & ~level_q;
    assign handshake = evt_valid & evt_ready;
    assign busy      = (state == OFFER) | (|pending);

    always_comb begin
        clr = '0;
        for (int i = 0; i < N_CH; i++) begin
            clr[i] = handshake && (evt_ch == CH_W'(i));
        end
    end

    // An edge coinciding with its own clear keeps the request alive without flagging overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= '0;
            pending <= '0;
            ovf     <= '0;
        end else begin
            level_q <= level_s;
            pending <= edge_det | (pending & ~clr);
            ovf     <= (edge_det & pending & ~clr) | (ovf & ~ovf_clr);
        end
    end

    // First pending channel at or after rr_ptr, wrapping modulo N_CH.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        cand_sum   = 0;
        for (int k = 0; k < N_CH; k++) begin
            cand_sum = int'(rr_ptr) + k;
            if (cand_sum >= N_CH) begin
                cand_sum = cand_sum - N_CH;
            end
            cand = CH_W'(cand_sum);
            if (!pick_found && pending[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            evt_ch <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            evt_ch <= evt_ch_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        evt_ch_nxt = evt_ch;
        rr_ptr_nxt = rr_ptr;
        evt_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    evt_ch_nxt = pick_idx;
                    state_nxt  = OFFER;
                end
            end
            OFFER: begin
                evt_valid = 1'b1;
                if (evt_ready) begin
                    rr_ptr_nxt = (evt_ch == CH_W'(N_CH - 1)) ? '0 : evt_ch + 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomised and directed bench for edge_event_arbiter against a behavioural event-queue model.
module tb_edge_event_arbiter;

    localparam int N = 4;

    logic         clk;
    logic         reset_n;
    logic         en;
    logic [N-1:0] level;
    logic         evt_valid;
    logic [1:0]   evt_ch;
    logic         evt_ready;
    logic [N-1:0] pending;
    logic [N-1:0] ovf;
    logic [N-1:0] ovf_clr;
    logic         busy;

    int total;
    int bad;

    bit m_pend[N];
    bit m_ovf[N];
    bit m_prev[N];
    bit m_s1[N];
    bit m_s2[N];
    bit m_offer;
    int m_ch;
    int m_rr;

    edge_event_arbiter #(.N_CH(N), .CH_W(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .level     (level),
        .evt_valid (evt_valid),
        .evt_ch    (evt_ch),
        .evt_ready (evt_ready),
        .pending   (pending),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_ovf[i]  = 0;
            m_prev[i] = 0;
            m_s1[i]   = 0;
            m_s2[i]   = 0;
        end
        m_offer = 0;
        m_ch    = 0;
        m_rr    = 0;
    endtask

    // One clock of the event-queue model, using the inputs currently applied.
    task automatic model_step();
        bit s[N];
        bit np[N];
        bit no[N];
        bit hs;
        int pick;
        for (int i = 0; i < N; i++) begin
`ifdef EDGE_ARB_SYNC_EN
            s[i]    = m_s2[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = level[i];
`else
            s[i] = level[i];
`endif
        end
        hs = m_offer && evt_ready;
        for (int i = 0; i < N; i++) begin
            bit e;
            bit c;
            e     = en && s[i] && !m_prev[i];
            c     = hs && (m_ch == i);
            np[i] = e || (m_pend[i] && !c);
            no[i] = (e && m_pend[i] && !c) || (m_ovf[i] && !ovf_clr[i]);
        end
        if (m_offer) begin
            if (hs) begin
                m_rr    = (m_ch + 1) % N;
                m_offer = 0;
            end
        end else begin
            pick = -1;
            for (int k = 0; k < N; k++) begin
                if (pick < 0 && m_pend[(m_rr + k) % N]) pick = (m_rr + k) % N;
            end
            if (pick >= 0) begin
                m_ch    = pick;
                m_offer = 1;
            end
        end
        for (int i = 0; i < N; i++) begin
            m_pend[i] = np[i];
            m_ovf[i]  = no[i];
            m_prev[i] = s[i];
        end
    endtask

    function automatic logic [N-1:0] exp_pend();
        for (int i = 0; i < N; i++) exp_pend[i] = m_pend[i];
    endfunction

    function automatic logic [N-1:0] exp_ovf();
        for (int i = 0; i < N; i++) exp_ovf[i] = m_ovf[i];
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        en        = 1'b1;
        level     = '0;
        evt_ready = 1'b0;
        ovf_clr   = '0;
        reset_n   = 1'b0;
        #2;
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if ({evt_valid, busy, pending, ovf} !== 10'b0) begin
            bad++;
            $display("[TB] FAIL reset_state: got %b want %b", {evt_valid, busy, pending, ovf}, 10'b0);
        end
        do_reset();
        tick();
        total++;
        if ({evt_valid, busy, pending, ovf} !== 10'b0) begin
            bad++;
            $display("[TB] FAIL reset_release: got %b want %b", {evt_valid, busy, pending, ovf}, 10'b0);
        end
    endtask

    task automatic test_single_edge();
        int n_valid;
        int ch_seen;
        n_valid = 0;
        ch_seen = -1;
        do_reset();
        evt_ready = 1'b1;
        level     = 4'b0100;
        for (int c = 0; c < 12; c++) begin
            tick();
            total++;
            if (pending !== exp_pend() || evt_valid !== m_offer) begin
                bad++;
                $display("[TB] FAIL single_cycle%0d: got p=%b v=%b want p=%b v=%b",
                         c, pending, evt_valid, exp_pend(), m_offer);
            end
            if (evt_valid === 1'b1) begin
                n_valid++;
                ch_seen = int'(evt_ch);
            end
        end
        total++;
        if (n_valid != 1 || ch_seen != 2 || pending !== 4'b0) begin
            bad++;
            $display("[TB] FAIL single_event: got n=%0d ch=%0d p=%b want n=1 ch=2 p=0000",
                     n_valid, ch_seen, pending);
        end
    endtask

    task automatic test_all_rise();
        int order[$];
        int when[$];
        do_reset();
        evt_ready = 1'b1;
        level     = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (evt_valid === 1'b1) begin
                order.push_back(int'(evt_ch));
                when.push_back(c);
            end
        end
        total++;
        if (order.size() != 4) begin
            bad++;
            $display("[TB] FAIL all_rise_count: got %0d want 4", order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (order[i] != i || (i > 0 && when[i] - when[i-1] != 2)) begin
                    bad++;
                    $display("[TB] FAIL all_rise_grant%0d: got ch=%0d want ch=%0d", i, order[i], i);
                end
            end
        end
        total++;
        if (ovf !== 4'b0) begin
            bad++;
            $display("[TB] FAIL all_rise_ovf: got %b want 0000", ovf);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        level = 4'b0010;
        tick();
        tick();
        level = 4'b0000;
        tick();
        level = 4'b0010;
        tick();
        total++;
        if (ovf !== 4'b0010 || pending !== 4'b0010 || evt_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL overflow_set: got ovf=%b p=%b v=%b want ovf=0010 p=0010 v=1",
                     ovf, pending, evt_valid);
        end
        ovf_clr = 4'b0010;
        tick();
        ovf_clr = 4'b0000;
        total++;
        if (ovf !== 4'b0000 || ovf !== exp_ovf()) begin
            bad++;
            $display("[TB] FAIL overflow_clear: got %b want 0000", ovf);
        end
        evt_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_edge_with_handshake();
        int order[$];
        do_reset();
        level = 4'b1111;
        tick();
        tick();
        total++;
        if (evt_valid !== 1'b1 || evt_ch !== 2'd0) begin
            bad++;
            $display("[TB] FAIL ewh_offer: got v=%b ch=%0d want v=1 ch=0", evt_valid, evt_ch);
        end
        level = 4'b1110;
        tick();
        level     = 4'b1111;
        evt_ready = 1'b1;
        tick();
        total++;
        if (pending !== 4'b1111 || ovf !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL ewh_keep: got p=%b ovf=%b want p=1111 ovf=0000", pending, ovf);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            if (evt_valid === 1'b1) order.push_back(int'(evt_ch));
        end
        total++;
        if (order.size() != 4 || order[0] != 1 || order[1] != 2 || order[2] != 3 || order[3] != 0) begin
            bad++;
            $display("[TB] FAIL ewh_order: got %p want 1 2 3 0", order);
        end
    endtask

    task automatic test_enable();
        do_reset();
        level = 4'b0010;
        tick();
        tick();
        en    = 1'b0;
        level = 4'b1010;
        tick();
        total++;
        if (pending !== 4'b0010 || evt_valid !== 1'b1 || evt_ch !== 2'd1) begin
            bad++;
            $display("[TB] FAIL enable_gate: got p=%b v=%b ch=%0d want p=0010 v=1 ch=1",
                     pending, evt_valid, evt_ch);
        end
        evt_ready = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if (pending !== 4'b0000 || evt_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL enable_drain: got p=%b v=%b b=%b want p=0000 v=0 b=0",
                     pending, evt_valid, busy);
        end
        en = 1'b1;
    endtask

    task automatic test_reset_mid_offer();
        do_reset();
        level = 4'b0100;
        tick();
        level = 4'b0000;
        tick();
        level = 4'b0100;
        tick();
        total++;
        if (evt_valid !== 1'b1 || ovf !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL midreset_pre: got v=%b ovf=%b want v=1 ovf=0100", evt_valid, ovf);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({evt_valid, busy, pending, ovf} !== 10'b0) begin
            bad++;
            $display("[TB] FAIL midreset_drop: got %b want %b", {evt_valid, busy, pending, ovf}, 10'b0);
        end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            en        = ($urandom_range(0, 9) != 0);
            level     = level ^ N'($urandom_range(0, 15) & $urandom_range(0, 15));
            evt_ready = $urandom_range(0, 2) != 0;
            ovf_clr   = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : '0;
            tick();
            total++;
            if (pending !== exp_pend() || ovf !== exp_ovf() || evt_valid !== m_offer ||
                busy !== (m_offer || (exp_pend() != 0)) ||
                (m_offer && int'(evt_ch) != m_ch)) begin
                bad++;
                $display("[TB] FAIL random_cycle%0d: got p=%b o=%b v=%b ch=%0d b=%b want p=%b o=%b v=%b ch=%0d",
                         c, pending, ovf, evt_valid, evt_ch, busy, exp_pend(), exp_ovf(), m_offer, m_ch);
            end
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset_n   = 1'b0;
        en        = 1'b0;
        level     = '0;
        evt_ready = 1'b0;
        ovf_clr   = '0;
        model_reset();
        test_reset();
        test_single_edge();
        test_all_rise();
        test_overflow();
        test_edge_with_handshake();
        test_enable();
        test_reset_mid_offer();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
